// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I opcode constants, fetch FSM states and predecode bundle
package rv32i_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {RST, FETCH, ISSUE} fetch_state_t;
  typedef struct packed {
    logic r_type;
    logic i_type;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic illegal;
    logic [2:0] fun3;
    logic fun7;
  } predecode_t;
endpackage

// File: rtl/rv32i_predecode.sv
// rv32i_predecode: combinational instr -> one-hot class flags, fun3, fun7, illegal
module rv32i_predecode
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output predecode_t  pd
);
  logic [6:0] op;
  assign op = instr[6:0];
  always_comb begin
    pd = '0;
    pd.r_type = op == OP_R;
    pd.i_type = op == OP_I;
    pd.load = op == OP_LOAD;
    pd.store = op == OP_STORE;
    pd.branch = op == OP_BRANCH;
    pd.jal = op == OP_JAL;
    pd.jalr = op == OP_JALR;
    pd.lui = op == OP_LUI;
    pd.auipc = op == OP_AUIPC;
    pd.illegal = !(pd.r_type || pd.i_type || pd.load || pd.store || pd.branch ||
                   pd.jal || pd.jalr || pd.lui || pd.auipc);
    pd.fun3 = instr[14:12];
    pd.fun7 = (pd.r_type || (pd.i_type && instr[14:12] == 3'b101)) && instr[30];
  end
endmodule

// File: rtl/fetch_predecode.sv
// fetch_predecode: PC owner, single-outstanding imem fetch, registered predecode for the core
module fetch_predecode
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [2:0]  fun3,
  output logic        fun7,
  output logic        r_type,
  output logic        i_type,
  output logic        load,
  output logic        store,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        lui,
  output logic        auipc,
  output logic        illegal,
  output logic        misaligned
);
  fetch_state_t state, state_nx;
  predecode_t pd, pd_q;
  logic fetch_done, consume;
  rv32i_predecode u_predecode (.instr(imem_rdata), .pd(pd));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RST;
    else state <= state_nx;
  always_comb begin
    fetch_done = state == FETCH && imem_valid;
    consume = state == ISSUE && instr_ready;
    state_nx = state == RST ? FETCH :
               fetch_done   ? ISSUE :
               consume      ? FETCH : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      instr <= NOP;
      pd_q <= '0;
      instr_valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      if (fetch_done) begin
        instr <= imem_rdata;
        pd_q <= pd;
        instr_valid <= 1'b1;
      end
      if (consume) begin
        pc <= redirect ? {redirect_pc[31:2], 2'b00} : pc_plus4;
        instr_valid <= 1'b0;
        if (redirect && redirect_pc[1:0] != 2'b00) misaligned <= 1'b1;
      end
    end
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  assign fun3 = pd_q.fun3 & {3{instr_valid}};
  assign fun7 = pd_q.fun7 & instr_valid;
  assign r_type = pd_q.r_type & instr_valid;
  assign i_type = pd_q.i_type & instr_valid;
  assign load = pd_q.load & instr_valid;
  assign store = pd_q.store & instr_valid;
  assign branch = pd_q.branch & instr_valid;
  assign jal = pd_q.jal & instr_valid;
  assign jalr = pd_q.jalr & instr_valid;
  assign lui = pd_q.lui & instr_valid;
  assign auipc = pd_q.auipc & instr_valid;
  assign illegal = pd_q.illegal & instr_valid;
endmodule

// File: doc/fetch_predecode.md
Name: fetch_predecode

Overview:
- Instruction-side front end of the RV32I core. Owns the PC and fetches instruction words from the instruction memory over a req/valid handshake.
- Registers each fetched word and pre-decodes it into the one-hot class flags plus fun3/fun7 that the control decoder consumes.
- Accepts the core's taken-branch/jump redirect when the core consumes an instruction.
- One instruction is in flight at a time (no prefetch).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, held until imem_valid
- imem_addr  out  32  fetch address (= pc), stable while imem_req=1
- imem_valid  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr_ready  in  1  core consumes the current instruction this cycle
- redirect  in  1  sampled only with instr_ready: take redirect_pc
- redirect_pc  in  32  branch/jump target
- instr_valid  out  1  instr and all flags below are valid
- instr  out  32  registered instruction
- pc  out  32  address of instr
- pc_plus4  out  32  pc+4, used for jal/jalr link
- fun3  out  3  instr[14:12]
- fun7  out  1  see Behaviour
- r_type, i_type, load, store, branch, jal, jalr, lui, auipc  out  1 each  one-hot class flags
- illegal  out  1  opcode matches no class
- misaligned  out  1  sticky: a redirect_pc had bits[1:0]≠0

Behaviour:
- Reset (async assert):
  - state=RST, pc=RESET_PC, instr=32'h0000_0013.
  - instr_valid=0, imem_req=0, misaligned=0, all flags 0.
- States and transitions:
  - RST → FETCH on the first clk edge after rst deasserts. imem_valid is ignored in RST.
  - FETCH: imem_req=1, imem_addr=pc. When imem_valid=1: latch imem_rdata into instr, register the decode, set instr_valid=1, go to ISSUE. Otherwise stay; any number of wait cycles is allowed.
  - ISSUE: imem_req=0, instr_valid=1, outputs held stable. When instr_ready=1:
    - pc <= redirect ? {redirect_pc[31:2],2'b00} : pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
    - instr_valid <= 0; go to FETCH.
  - ISSUE with instr_ready=0: hold indefinitely (stall).
- Latency and throughput:
  - instr_valid rises the cycle after imem_valid.
  - Best-case throughput is 1 instruction per 2 cycles.
- Decode (registered together with instr; all flags forced 0 while instr_valid=0):
  - opcode 0110011 r_type, 0010011 i_type, 0000011 load, 0100011 store.
  - opcode 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc.
  - Any other opcode: illegal=1, all class flags 0. instr_valid is still asserted; the core decides how to handle it.
- fun7 rules:
  - r_type: fun7=instr[30].
  - i_type with fun3=101: fun7=instr[30] (srli/srai).
  - All other cases: fun7=0, so addi/slli/etc. always present fun7=0.
- pc_plus4 = pc+4, combinational from the pc register.
- misaligned: set when instr_ready&redirect&(redirect_pc[1:0]≠0). The fetch still proceeds with the low bits cleared. Cleared only by rst.
- redirect without instr_ready, or in any state other than ISSUE: ignored.
- imem_valid outside FETCH: ignored.
- Reset mid-FETCH: request drops immediately (async). A response arriving in RST is discarded. Fetch restarts at RESET_PC.

Decomposition:
- Shared package rv32i_pkg:
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - NOP constant 32'h0000_0013.
  - Fetch state enum {RST, FETCH, ISSUE}.
- Sub-module rv32i_predecode: purely combinational instr → class flags, fun3, fun7, illegal. fetch_predecode registers its outputs.

Test Plan:
- Reset then release, imem_valid=1 immediately, instr_ready=1 → fetch addresses 0x0, 0x4, 0x8. instr_valid pulses every 2nd cycle. pc tracks the fetch address.
- Fetch 0x40A0_D093 (srai x1,x1,10) then 0x00A0_8093 (addi x1,x1,10) →
  - srai: i_type=1, fun3=101, fun7=1.
  - addi: i_type=1, fun3=000, fun7=0.
- Fetch 0x0000_006F (jal) at pc=0x10; assert instr_ready with redirect=1, redirect_pc=0x100 →
  - jal=1, pc_plus4=0x14.
  - Next imem_addr=0x100.
  - redirect_pc=0x102 instead → imem_addr=0x100, misaligned=1.
- imem_valid delayed 5 cycles; instr_ready low 3 cycles in ISSUE →
  - imem_req and imem_addr stable throughout the wait.
  - instr, pc and flags unchanged during the stall.
  - No second request issued.
- Fetch 0x0000_0073 (ecall) → illegal=1, all class flags 0, instr_valid=1.
- Assert rst during FETCH with imem_valid arriving in the same cycle →
  - imem_req=0 and instr_valid=0 at once.
  - After release the first fetch is at RESET_PC.
- pc=0xFFFF_FFFC, no redirect → next fetch at 0x0000_0000.
